// File: rtl/gth_tx_framer.sv
// GTH TX framer: buffers 32-bit user words, then emits training bursts, user data and K-char idle fill.
// Optional PRBS-31 data-state test pattern is enabled by defining GTH_TX_PRBS_EN.
module gth_tx_framer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TRAIN_WORDS = 64,
  parameter logic [31:0] TRAIN_WORD  = 32'hBC4A4ABC,
  parameter logic [31:0] IDLE_WORD   = 32'hBC3C3CBC,
  parameter logic [3:0]  TRAIN_CTRL  = 4'b1001,
  parameter logic [3:0]  IDLE_CTRL   = 4'b1001
) (
  input  logic        clk,
  input  logic        userclk_tx_reset_int,
  input  logic        tx_active_i,
  input  logic        train_req_i,
`ifdef GTH_TX_PRBS_EN
  input  logic        prbs_sel_i,
`endif
  input  logic [31:0] user_data_i,
  input  logic        user_valid_i,
  output logic        user_ready_o,
  output logic [31:0] gt_txdata_o,
  output logic [3:0]  gt_txctrl_o,
  output logic        link_up_o,
  output logic [1:0]  state_o,
  output logic [15:0] underflow_cnt_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
  localparam logic [CW-1:0] TRAIN_LAST = CW'(TRAIN_WORDS - 1);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_TRAIN = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] train_cnt_q, train_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_vis_q, wr_vis_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   txdata_q, txdata_d;
  logic [3:0]    txctrl_q, txctrl_d;
  logic          ready_q, ready_d;
  logic          link_q, link_d;
  logic [15:0]   ucnt_q, ucnt_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic avail;
  logic full_d;

`ifdef GTH_TX_PRBS_EN
  logic [30:0] lfsr_q, lfsr_d;
  logic [31:0] prbs_word;
  logic [30:0] lfsr_nx;

  // 32 serial steps of x^31+x^28+1; first generated bit lands in the MSB
  function automatic logic [62:0] prbs31_step(input logic [30:0] seed);
    logic [30:0] s;
    logic [31:0] w;
    logic        b;
    s = seed;
    w = '0;
    for (int i = 31; i >= 0; i--) begin
      b    = s[30] ^ s[27];
      s    = {s[29:0], b};
      w[i] = b;
    end
    return {w, s};
  endfunction

  assign {prbs_word, lfsr_nx} = prbs31_step(lfsr_q);
`endif

  // Next-state, FIFO pointer and registered-output computation
  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_vis_d    = wr_ptr_q;
    txdata_d    = IDLE_WORD;
    txctrl_d    = IDLE_CTRL;
    ucnt_d      = ucnt_q;
    push        = user_valid_i && ready_q;
    pop         = 1'b0;
    // read side sees writes one cycle late, giving a two-edge accept-to-output latency
    avail       = (rd_ptr_q != wr_vis_q);
`ifdef GTH_TX_PRBS_EN
    lfsr_d      = '1;
`endif

    if (!tx_active_i) begin
      state_d     = ST_OFF;
      train_cnt_d = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d     = ST_TRAIN;
          train_cnt_d = '0;
        end
        ST_TRAIN: begin
          if (train_cnt_q == TRAIN_LAST) begin
            train_cnt_d = '0;
            state_d     = train_req_i ? ST_TRAIN : ST_DATA;
          end else begin
            train_cnt_d = train_cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (train_req_i) begin
            state_d     = ST_TRAIN;
            train_cnt_d = '0;
          end
        end
        default: begin
          state_d     = ST_OFF;
          train_cnt_d = '0;
        end
      endcase
    end

    // Outputs belong to the cycle being entered, so they track state_d
    case (state_d)
      ST_TRAIN: begin
        txdata_d = TRAIN_WORD;
        txctrl_d = TRAIN_CTRL;
      end
      ST_DATA: begin
`ifdef GTH_TX_PRBS_EN
        lfsr_d = lfsr_q;
        if (prbs_sel_i) begin
          txdata_d = prbs_word;
          txctrl_d = 4'b0000;
          lfsr_d   = lfsr_nx;
        end else
`endif
        if (avail) begin
          pop      = 1'b1;
          txdata_d = mem_q[rd_ptr_q[AW-1:0]];
          txctrl_d = 4'b0000;
        end else if (ucnt_q != 16'hFFFF) begin
          ucnt_d = ucnt_q + 16'd1;
        end
      end
      default: ;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (state_d == ST_OFF) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      wr_vis_d = '0;
    end

    full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    ready_d = !full_d && (state_d != ST_OFF);
    link_d  = (state_d == ST_DATA);
  end

  always_ff @(posedge clk or posedge userclk_tx_reset_int) begin
    if (userclk_tx_reset_int) begin
      state_q     <= ST_OFF;
      train_cnt_q <= '0;
      wr_ptr_q    <= '0;
      wr_vis_q    <= '0;
      rd_ptr_q    <= '0;
      txdata_q    <= IDLE_WORD;
      txctrl_q    <= IDLE_CTRL;
      ready_q     <= 1'b0;
      link_q      <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_vis_q    <= wr_vis_d;
      rd_ptr_q    <= rd_ptr_d;
      txdata_q    <= txdata_d;
      txctrl_q    <= txctrl_d;
      ready_q     <= ready_d;
      link_q      <= link_d;
      ucnt_q      <= ucnt_d;
    end
  end

`ifdef GTH_TX_PRBS_EN
  always_ff @(posedge clk or posedge userclk_tx_reset_int) begin
    if (userclk_tx_reset_int) lfsr_q <= '1;
    else                      lfsr_q <= lfsr_d;
  end
`endif

  // Storage needs no reset; occupancy is defined by the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= user_data_i;
  end

  assign user_ready_o    = ready_q;
  assign gt_txdata_o     = txdata_q;
  assign gt_txctrl_o     = txctrl_q;
  assign link_up_o       = link_q;
  assign state_o         = state_q;
  assign underflow_cnt_o = ucnt_q;

endmodule

// File: tb/tb_gth_tx_framer.sv
// Self-checking bench for gth_tx_framer: queue-based reference model plus scenario tasks.
module tb_gth_tx_framer;

  localparam int          DEPTH   = 4;
  localparam int          TW      = 64;
  localparam logic [31:0] TRAIN_W = 32'hBC4A4ABC;
  localparam logic [31:0] IDLE_W  = 32'hBC3C3CBC;
  localparam logic [3:0]  K_CTRL  = 4'b1001;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        tx_active  = 1'b0;
  logic        train_req  = 1'b0;
  logic        user_valid = 1'b0;
  logic [31:0] user_data  = '0;

  logic        user_ready_o;
  logic [31:0] gt_txdata_o;
  logic [3:0]  gt_txctrl_o;
  logic        link_up_o;
  logic [1:0]  state_o;
  logic [15:0] underflow_cnt_o;

  int checks = 0;
  int errors = 0;

  gth_tx_framer #(
    .FIFO_DEPTH (DEPTH),
    .TRAIN_WORDS(TW),
    .TRAIN_WORD (TRAIN_W),
    .IDLE_WORD  (IDLE_W),
    .TRAIN_CTRL (K_CTRL),
    .IDLE_CTRL  (K_CTRL)
  ) dut (
    .clk                 (clk),
    .userclk_tx_reset_int(rst),
    .tx_active_i         (tx_active),
    .train_req_i         (train_req),
    .user_data_i         (user_data),
    .user_valid_i        (user_valid),
    .user_ready_o        (user_ready_o),
    .gt_txdata_o         (gt_txdata_o),
    .gt_txctrl_o         (gt_txctrl_o),
    .link_up_o           (link_up_o),
    .state_o             (state_o),
    .underflow_cnt_o     (underflow_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: link state plus a queue of words stamped with their accept edge
  logic [1:0]  m_state;
  int          m_tleft;
  logic [31:0] m_q[$];
  int          m_stamp[$];
  int          edge_n;
  logic        m_ready, m_link;
  logic [31:0] m_data;
  logic [3:0]  m_ctrl;
  logic [15:0] m_ucnt;

  always @(posedge clk or posedge rst) begin : ref_model
    logic       push;
    logic [1:0] ns;
    if (rst) begin
      m_state = 2'd0; m_tleft = 0; m_q.delete(); m_stamp.delete(); edge_n = 0;
      m_ready = 1'b0; m_link = 1'b0; m_data = IDLE_W; m_ctrl = K_CTRL; m_ucnt = 16'd0;
    end else begin
      edge_n++;
      push = user_valid && m_ready;
      if (!tx_active) ns = 2'd0;
      else if (m_state == 2'd0) begin ns = 2'd1; m_tleft = TW; end
      else if (m_state == 2'd1) begin
        if (m_tleft > 1) begin ns = 2'd1; m_tleft--; end
        else if (train_req) begin ns = 2'd1; m_tleft = TW; end
        else ns = 2'd2;
      end else if (train_req) begin ns = 2'd1; m_tleft = TW; end
      else ns = 2'd2;

      m_data = IDLE_W; m_ctrl = K_CTRL;
      if (ns == 2'd1) m_data = TRAIN_W;
      if (ns == 2'd2) begin
        if (m_q.size() > 0 && m_stamp[0] <= edge_n - 2) begin
          m_data = m_q.pop_front(); void'(m_stamp.pop_front()); m_ctrl = 4'b0000;
        end else if (m_ucnt != 16'hFFFF) m_ucnt++;
      end
      if (push) begin m_q.push_back(user_data); m_stamp.push_back(edge_n); end
      if (ns == 2'd0) begin m_q.delete(); m_stamp.delete(); end
      m_state = ns;
      m_ready = (m_q.size() < DEPTH) && (ns != 2'd0);
      m_link  = (ns == 2'd2);
    end
  end

  wire [55:0] act_w = {state_o, gt_txdata_o, gt_txctrl_o, link_up_o, user_ready_o, underflow_cnt_o};
  wire [55:0] exp_w = {m_state, m_data, m_ctrl, m_link, m_ready, m_ucnt};

  task automatic test_reset();
    rst = 1'b1;
    #23;
    checks++;
    if (act_w !== {2'd0, IDLE_W, K_CTRL, 1'b0, 1'b0, 16'd0}) begin
      errors++; $display("FAIL reset_values got=%h exp=%h", act_w, {2'd0, IDLE_W, K_CTRL, 1'b0, 1'b0, 16'd0});
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (act_w !== exp_w) begin errors++; $display("FAIL off_idle t=%0t got=%h exp=%h", $time, act_w, exp_w); end
    end
  endtask

  task automatic test_train_entry();
    int ntrain = 0;
    tx_active = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      checks++;
      if (act_w !== exp_w) begin errors++; $display("FAIL train_entry t=%0t got=%h exp=%h", $time, act_w, exp_w); end
      if (state_o == 2'd1) ntrain++;
    end
    checks++;
    if (ntrain != TW) begin errors++; $display("FAIL train_len got=%0d exp=%0d", ntrain, TW); end
    checks++;
    if ({link_up_o, state_o, gt_txdata_o} !== {1'b1, 2'd2, IDLE_W}) begin
      errors++; $display("FAIL data_idle got=%b/%0d/%h exp=1/2/%h", link_up_o, state_o, gt_txdata_o, IDLE_W);
    end
  endtask

  task automatic test_stream();
    int   sent = 0, cyc = 0, acc_cyc = -1, out_cyc = -1;
    logic r;
    user_valid = 1'b1; user_data = 32'd1;
    while (sent < 16 && cyc < 40) begin
      r = user_ready_o;
      checks++;
      if (r !== 1'b1) begin errors++; $display("FAIL stream_ready t=%0t got=%b exp=1", $time, r); end
      @(posedge clk); #1; cyc++;
      if (r) begin if (sent == 0) acc_cyc = cyc; sent++; end
      checks++;
      if (act_w !== exp_w) begin errors++; $display("FAIL stream t=%0t got=%h exp=%h", $time, act_w, exp_w); end
      if (gt_txdata_o == 32'd1 && gt_txctrl_o == 4'b0000 && out_cyc < 0) out_cyc = cyc;
      user_data = 32'(sent + 1);
      if (sent == 16) user_valid = 1'b0;
    end
    user_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; cyc++;
      checks++;
      if (act_w !== exp_w) begin errors++; $display("FAIL stream_drain t=%0t got=%h exp=%h", $time, act_w, exp_w); end
      if (gt_txdata_o == 32'd1 && gt_txctrl_o == 4'b0000 && out_cyc < 0) out_cyc = cyc;
    end
    checks++;
    if (out_cyc - acc_cyc != 2) begin errors++; $display("FAIL stream_latency got=%0d exp=2", out_cyc - acc_cyc); end
  endtask

  task automatic test_train_fill();
    logic [31:0] w[4];
    int          n = 0, guard = 0;
    logic [15:0] u0;
    logic        r;
    train_req = 1'b1;
    @(posedge clk); #1;
    train_req = 1'b0;
    foreach (w[i]) w[i] = $urandom;
    user_valid = 1'b1; user_data = w[0];
    while (n < 4 && guard < 10) begin
      r = user_ready_o;
      @(posedge clk); #1; guard++;
      checks++;
      if (act_w !== exp_w) begin errors++; $display("FAIL fill_push t=%0t got=%h exp=%h", $time, act_w, exp_w); end
      if (r) n++;
      if (n < 4) user_data = w[n];
    end
    user_valid = 1'b0;
    checks++;
    if (user_ready_o !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b exp=0", user_ready_o); end
    guard = 0;
    u0 = underflow_cnt_o;
    while (state_o != 2'd2 && guard < 100) begin
      u0 = underflow_cnt_o;
      @(posedge clk); #1; guard++;
      checks++;
      if (act_w !== exp_w) begin errors++; $display("FAIL fill_train t=%0t got=%h exp=%h", $time, act_w, exp_w); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({gt_txdata_o, gt_txctrl_o, underflow_cnt_o} !== {w[i], 4'b0000, u0}) begin
        errors++; $display("FAIL fill_word%0d got=%h/%b/%0d exp=%h/0000/%0d", i, gt_txdata_o, gt_txctrl_o, underflow_cnt_o, w[i], u0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_train_req();
    logic [31:0] w1, w2;
    int          n = 0;
    w1 = $urandom; w2 = $urandom;
    user_valid = 1'b1; user_data = w1;
    @(posedge clk); #1;
    user_data = w2;
    @(posedge clk); #1;
    user_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({gt_txdata_o, gt_txctrl_o} !== {w1, 4'b0000}) begin
      errors++; $display("FAIL treq_first got=%h/%b exp=%h/0000", gt_txdata_o, gt_txctrl_o, w1);
    end
    train_req = 1'b1;
    @(posedge clk); #1;
    train_req = 1'b0;
    while (state_o == 2'd1 && n < 100) begin
      n++;
      checks++;
      if (act_w !== exp_w) begin errors++; $display("FAIL treq_burst t=%0t got=%h exp=%h", $time, act_w, exp_w); end
      @(posedge clk); #1;
    end
    checks++;
    if (n != TW) begin errors++; $display("FAIL treq_len got=%0d exp=%0d", n, TW); end
    checks++;
    if ({gt_txdata_o, gt_txctrl_o} !== {w2, 4'b0000}) begin
      errors++; $display("FAIL treq_second got=%h/%b exp=%h/0000", gt_txdata_o, gt_txctrl_o, w2);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    train_req = 1'b1;
    for (int i = 0; i < 300 && (n == 0 || state_o == 2'd1); i++) begin
      @(posedge clk); #1;
      if (i == 99) train_req = 1'b0;
      checks++;
      if (act_w !== exp_w) begin errors++; $display("FAIL b2b t=%0t got=%h exp=%h", $time, act_w, exp_w); end
      if (state_o == 2'd1) n++;
    end
    train_req = 1'b0;
    checks++;
    if (n != 2 * TW) begin errors++; $display("FAIL b2b_len got=%0d exp=%0d", n, 2 * TW); end
  endtask

  task automatic test_deactivate();
    int n = 0;
    user_valid = 1'b1; user_data = $urandom;
    @(posedge clk); #1;
    user_data = $urandom;
    @(posedge clk); #1;
    user_data = $urandom; tx_active = 1'b0;
    @(posedge clk); #1;
    user_valid = 1'b0;
    checks++;
    if ({state_o, user_ready_o, link_up_o} !== {2'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL deact_off got=%0d/%b/%b exp=0/0/0", state_o, user_ready_o, link_up_o);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (act_w !== exp_w) begin errors++; $display("FAIL deact_hold t=%0t got=%h exp=%h", $time, act_w, exp_w); end
    end
    tx_active = 1'b1;
    @(posedge clk); #1;
    while (state_o == 2'd1 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != TW) begin errors++; $display("FAIL deact_train_len got=%0d exp=%0d", n, TW); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({gt_txdata_o, gt_txctrl_o} !== {IDLE_W, K_CTRL}) begin
        errors++; $display("FAIL deact_stale got=%h/%b exp=%h/%b", gt_txdata_o, gt_txctrl_o, IDLE_W, K_CTRL);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      user_valid = ($urandom_range(0, 9) < 6);
      user_data  = $urandom;
      train_req  = ($urandom_range(0, 249) == 0);
      tx_active  = ($urandom_range(0, 599) != 0);
      @(posedge clk); #1;
      checks++;
      if (act_w !== exp_w) begin errors++; $display("FAIL random t=%0t got=%h exp=%h", $time, act_w, exp_w); end
    end
    user_valid = 1'b0; train_req = 1'b0; tx_active = 1'b1;
  endtask

  task automatic test_underflow_sat();
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk); #1;
      checks++;
      if (act_w !== exp_w) begin errors++; $display("FAIL underflow t=%0t got=%h exp=%h", $time, act_w, exp_w); end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({state_o, underflow_cnt_o} !== {2'd2, 16'hFFFF}) begin
        errors++; $display("FAIL underflow_sat got=%0d/%h exp=2/ffff", state_o, underflow_cnt_o);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_train_entry();
    test_stream();
    test_train_fill();
    test_train_req();
    test_back_to_back();
    test_deactivate();
    test_random();
    test_underflow_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
